// File: rtl/display_pkg.sv
// Shared types and constants for the 2-digit multiplexed 7-segment scan display.
package display_pkg;

   typedef enum logic [2:0] {
      S_OFF  = 3'd0,
      S_ONES = 3'd1,
      S_GAP0 = 3'd2,
      S_TENS = 3'd3,
      S_GAP1 = 3'd4
   } state_t;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   // Active-low digit enables: an[0]=ones, an[1]=tens
   localparam logic [1:0] AN_OFF  = 2'b11;
   localparam logic [1:0] AN_ONES = 2'b10;
   localparam logic [1:0] AN_TENS = 2'b01;

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
   } disp_out_t;

   localparam disp_out_t DISP_DARK = '{an: AN_OFF, seg: SEG_BLANK};

endpackage

// File: rtl/count_display_scan_if.sv
// Counter-to-display bus: count value in, multiplexed segment/anode drive out.
interface count_display_scan_if;

   logic [3:0] count_in;
   logic [6:0] seg;
   logic [1:0] an;

   modport master (
      output count_in,
      input  seg,
      input  an
   );

   modport slave (
      input  count_in,
      output seg,
      output an
   );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; codes above 9 go dark.
module seg7_decoder
   import display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/count_display_scan.sv
// Scans a 4-bit count onto a 2-digit common-anode display with dark gaps between digits.
// Optional macro LEADING_ZERO_BLANK_EN darkens the tens digit when it is zero.
module count_display_scan
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GAP_CYCLES  = 2
)(
   input  logic               clk,
   input  logic               rst,
   count_display_scan_if.slave bus
);

   localparam int unsigned MAX_DUR = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
   localparam int unsigned CNT_W   = (MAX_DUR < 2) ? 1 : $clog2(MAX_DUR);
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(GAP_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] div_cnt;
   logic [3:0]       disp_val;
   logic             snap_en;
   logic [3:0]       tens;
   logic [3:0]       ones;
   logic [3:0]       digit;
   logic [6:0]       digit_seg;
   disp_out_t        out_q;
   disp_out_t        out_next;

   always_ff @(posedge clk) begin
      if (rst) state <= S_OFF;
      else     state <= state_next;
   end

   // Scan sequencing; a snapshot is taken on every entry into the ones phase
   always_comb begin
      state_next = state;
      snap_en    = 1'b0;
      case (state)
         S_OFF:  state_next = S_ONES;
         S_ONES: if (div_cnt == LAST_DIGIT) state_next = S_GAP0;
         S_GAP0: if (div_cnt == LAST_GAP)   state_next = S_TENS;
         S_TENS: if (div_cnt == LAST_DIGIT) state_next = S_GAP1;
         S_GAP1: if (div_cnt == LAST_GAP)   state_next = S_ONES;
         default: state_next = S_OFF;
      endcase
      if ((state_next == S_ONES) && (state != S_ONES)) snap_en = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)                       div_cnt <= '0;
      else if (state_next != state)  div_cnt <= '0;
      else                           div_cnt <= div_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)          disp_val <= 4'd0;
      else if (snap_en) disp_val <= bus.count_in;
   end

   assign tens  = (disp_val >= 4'd10) ? 4'd1 : 4'd0;
   assign ones  = (tens != 4'd0) ? (disp_val - 4'd10) : disp_val;
   assign digit = (state == S_TENS) ? tens : ones;

   seg7_decoder u_dec (
      .digit (digit),
      .seg   (digit_seg)
   );

   // Drive selection for the current phase; registered below so pins lag state by one cycle
   always_comb begin
      out_next = DISP_DARK;
      case (state)
         S_ONES: out_next = '{an: AN_ONES, seg: digit_seg};
         S_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
            if (tens != 4'd0) out_next = '{an: AN_TENS, seg: digit_seg};
`else
            out_next = '{an: AN_TENS, seg: digit_seg};
`endif
         end
         default: out_next = DISP_DARK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) out_q <= DISP_DARK;
      else     out_q <= out_next;
   end

   assign bus.seg = out_q.seg;
   assign bus.an  = out_q.an;

endmodule

// File: tb/tb_count_display_scan.sv
// Self-checking bench: fixed vector table, corner sequences, and random stimulus vs a frame-position model.
module tb_count_display_scan;

   localparam int R     = 4;
   localparam int G     = 1;
   localparam int FRAME = 2 * (R + G);

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [1:0] TZ_AN  = 2'b11;
   localparam logic [6:0] TZ_SEG = 7'h7F;
`else
   localparam logic [1:0] TZ_AN  = 2'b01;
   localparam logic [6:0] TZ_SEG = 7'b1000000;
`endif

   typedef struct {
      logic       r;
      logic [3:0] c;
      logic [1:0] an;
      logic [6:0] seg;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   k      = 0;
   logic [3:0] snap = 4'd0;
   logic [6:0] enc_tab [10];
   vec_t tbl [24];

   count_display_scan_if bus ();

   count_display_scan #(
      .REFRESH_DIV (R),
      .GAP_CYCLES  (G)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [3:0] c, input logic [1:0] a, input logic [6:0] s);
      vec_t v;
      v.r = r; v.c = c; v.an = a; v.seg = s;
      return v;
   endfunction

   // Apply inputs away from the edge, advance one edge, track edges since release and snapshots
   task automatic drive(input logic r, input logic [3:0] c);
      @(negedge clk);
      rst          = r;
      bus.count_in = c;
      @(posedge clk);
      if (r) k = 0;
      else begin
         k++;
         if (((k - 1) % FRAME) == 0) snap = c;
      end
      #1;
   endtask

   task automatic check(input string name, input logic [1:0] ea, input logic [6:0] es);
      n_chk++;
      if (bus.an !== ea || bus.seg !== es) begin
         n_fail++;
         $display("FAIL %s (edge %0d): an=%b seg=%b, expected an=%b seg=%b", name, k, bus.an, bus.seg, ea, es);
      end
   endtask

   // Output position in the frame is two edges behind release (one for state entry, one for the output register)
   task automatic check_model(input string name);
      logic [1:0] ea;
      logic [6:0] es;
      int p, t, o;
      ea = 2'b11;
      es = 7'h7F;
      if (k >= 2) begin
         p = (k - 2) % FRAME;
         t = int'(snap) / 10;
         o = int'(snap) % 10;
         if (p < R) begin
            ea = 2'b10;
            es = enc_tab[o];
         end else if (p >= R + G && p < 2 * R + G) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (t != 0) begin
               ea = 2'b01;
               es = enc_tab[t];
            end
`else
            ea = 2'b01;
            es = enc_tab[t];
`endif
         end
      end
      check(name, ea, es);
   endtask

   initial begin
      logic [3:0] cur;
      int guard;
      bus.count_in = 4'd0;
      enc_tab[0] = 7'b1000000; enc_tab[1] = 7'b1111001; enc_tab[2] = 7'b0100100;
      enc_tab[3] = 7'b0110000; enc_tab[4] = 7'b0011001; enc_tab[5] = 7'b0010010;
      enc_tab[6] = 7'b0000010; enc_tab[7] = 7'b1111000; enc_tab[8] = 7'b0000000;
      enc_tab[9] = 7'b0010000;

      // Reset, release with 7 (tens zero), then a frame of 13
      tbl[0]  = mk(1'b1, 4'd7,  2'b11, 7'h7F);
      tbl[1]  = mk(1'b1, 4'd7,  2'b11, 7'h7F);
      tbl[2]  = mk(1'b1, 4'd7,  2'b11, 7'h7F);
      tbl[3]  = mk(1'b0, 4'd7,  2'b11, 7'h7F);
      tbl[4]  = mk(1'b0, 4'd7,  2'b10, 7'b1111000);
      tbl[5]  = mk(1'b0, 4'd7,  2'b10, 7'b1111000);
      tbl[6]  = mk(1'b0, 4'd7,  2'b10, 7'b1111000);
      tbl[7]  = mk(1'b0, 4'd7,  2'b10, 7'b1111000);
      tbl[8]  = mk(1'b0, 4'd7,  2'b11, 7'h7F);
      tbl[9]  = mk(1'b0, 4'd7,  TZ_AN, TZ_SEG);
      tbl[10] = mk(1'b0, 4'd7,  TZ_AN, TZ_SEG);
      tbl[11] = mk(1'b0, 4'd7,  TZ_AN, TZ_SEG);
      tbl[12] = mk(1'b0, 4'd7,  TZ_AN, TZ_SEG);
      tbl[13] = mk(1'b0, 4'd13, 2'b11, 7'h7F);
      tbl[14] = mk(1'b0, 4'd13, 2'b10, 7'b0110000);
      tbl[15] = mk(1'b0, 4'd13, 2'b10, 7'b0110000);
      tbl[16] = mk(1'b0, 4'd13, 2'b10, 7'b0110000);
      tbl[17] = mk(1'b0, 4'd13, 2'b10, 7'b0110000);
      tbl[18] = mk(1'b0, 4'd13, 2'b11, 7'h7F);
      tbl[19] = mk(1'b0, 4'd13, 2'b01, 7'b1111001);
      tbl[20] = mk(1'b0, 4'd13, 2'b01, 7'b1111001);
      tbl[21] = mk(1'b0, 4'd13, 2'b01, 7'b1111001);
      tbl[22] = mk(1'b0, 4'd13, 2'b01, 7'b1111001);
      tbl[23] = mk(1'b0, 4'd13, 2'b11, 7'h7F);

      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].r, tbl[i].c);
         check($sformatf("table[%0d]", i), tbl[i].an, tbl[i].seg);
      end

      // Change 13 -> 4 while the tens digit is lit; shown only from the next frame
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 4'd13);
         check_model("mid_change_pre");
      end
      drive(1'b0, 4'd4);
      check("mid_change_tens_kept", 2'b01, 7'b1111001);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 4'd4);
         check_model("mid_change_post");
      end

      // Show 15, wrap to 0 mid-frame: remainder of the frame still shows 15
      guard = 0;
      while (((k - 1) % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
         drive(1'b0, 4'd4);
         check_model("align");
         guard++;
      end
      drive(1'b0, 4'd15);
      check_model("wrap_load");
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'd15);
         check_model("wrap_15");
      end
      for (int i = 0; i < 2 * FRAME; i++) begin
         drive(1'b0, 4'd0);
         check_model("wrap_0");
      end

      // Reset while the tens digit is being driven
      guard = 0;
      while (!(k >= 2 && ((k - 2) % FRAME) == R + G + 1) && guard < 2 * FRAME) begin
         drive(1'b0, 4'd12);
         check_model("pre_rst_mid");
         guard++;
      end
      if (guard >= 2 * FRAME) begin
         n_chk++;
         n_fail++;
         $display("FAIL align_timeout: guard=%0d, expected < %0d", guard, 2 * FRAME);
      end
      drive(1'b1, 4'd12);
      check("rst_mid_tens", 2'b11, 7'h7F);
      drive(1'b0, 4'd12);
      check("rst_release_1", 2'b11, 7'h7F);
      drive(1'b0, 4'd12);
      check("rst_release_2", 2'b10, 7'b0100100);
      for (int i = 0; i < FRAME; i++) begin
         drive(1'b0, 4'd12);
         check_model("after_rst");
      end

      // Random counter values and occasional resets
      cur = 4'd0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
         drive(($urandom_range(0, 59) == 0), cur);
         check_model("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
